// File: rtl/qei_pkg.sv
// Shared types and phase helpers for the quadrature encoder generator.
package qei_pkg;

    typedef enum logic {
        QEI_FWD = 1'b0,
        QEI_REV = 1'b1
    } qei_dir_e;

    typedef enum logic {
        IDLE,
        RUN
    } qei_gen_state_e;

    // {b,a} indexed by phase; forward walks the index upwards
    localparam logic [1:0] QEI_SEQ [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    function automatic logic [1:0] qei_phase_next(
        input logic [1:0] phase,
        input qei_dir_e   dir
    );
        if (dir == QEI_FWD)
            return phase + 2'd1;
        return phase - 2'd1;
    endfunction

endpackage

// File: rtl/qei_gen_timer.sv
// Reloadable down-counter producing one tick every max(period,1) enabled clocks.
module qei_gen_timer #(
    parameter int PERIOD_W = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_load,
    input  logic [PERIOD_W-1:0] i_period,
    input  logic                i_en,
    output logic                o_tick
);

    logic [PERIOD_W-1:0] r_cnt;
    logic [PERIOD_W-1:0] r_reload;
    logic [PERIOD_W-1:0] w_reload;

    // a zero period behaves like one clock per tick
    assign w_reload = (i_period == '0) ? '0 : i_period - 1'b1;
    assign o_tick   = i_en && (r_cnt == '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_reload <= '0;
        end else if (i_load) begin
            r_cnt    <= w_reload;
            r_reload <= w_reload;
        end else if (i_en) begin
            r_cnt <= (r_cnt == '0) ? r_reload : r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/qei_gen.sv
// Quadrature A/B generator driven by step commands; tracks emitted position.
// Optional index output enabled by defining QEI_GEN_INDEX_EN.
module qei_gen
    import qei_pkg::*;
#(
    parameter int STEPS_W  = 16,
    parameter int PERIOD_W = 16,
    parameter int POS_W    = 8,
    parameter int CPR      = 256
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic                i_cmd_dir,
    input  logic [STEPS_W-1:0]  i_cmd_steps,
    input  logic [PERIOD_W-1:0] i_cfg_period,
    input  logic                i_stop,
    output logic                o_enc_a,
    output logic                o_enc_b,
    output logic                o_enc_z,
    output logic [POS_W-1:0]    o_position,
    output logic                o_busy,
    output logic                o_done
);

    qei_gen_state_e r_state;
    qei_gen_state_e w_state_nxt;

    logic [1:0]         r_phase;
    logic [1:0]         r_ab;
    qei_dir_e           r_dir;
    logic [STEPS_W-1:0] r_rem;
    logic [POS_W-1:0]   r_pos;
    logic               r_done;

    logic       w_accept;
    logic       w_run;
    logic       w_tick;
    logic       w_step;
    logic       w_last;
    logic [1:0] w_phase_nxt;

    assign w_run       = (r_state == RUN);
    assign w_step      = w_run && w_tick && !i_stop;
    assign w_last      = w_step && (r_rem == STEPS_W'(1));
    assign w_phase_nxt = qei_phase_next(r_phase, r_dir);

    qei_gen_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (w_accept),
        .i_period (i_cfg_period),
        .i_en     (w_run),
        .o_tick   (w_tick)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_accept = i_cmd_valid;
                if (i_cmd_valid && (i_cmd_steps != '0))
                    w_state_nxt = RUN;
            end
            RUN: begin
                if (i_stop || w_last)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_phase <= 2'd0;
            r_ab    <= 2'b00;
            r_dir   <= QEI_FWD;
            r_rem   <= '0;
            r_pos   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= (w_accept && (i_cmd_steps == '0)) || w_last;
            if (w_accept) begin
                r_dir <= qei_dir_e'(i_cmd_dir);
                r_rem <= i_cmd_steps;
            end else if (w_step) begin
                r_rem   <= r_rem - 1'b1;
                r_phase <= w_phase_nxt;
                r_ab    <= QEI_SEQ[w_phase_nxt];
                r_pos   <= (r_dir == QEI_FWD) ? r_pos + 1'b1 : r_pos - 1'b1;
            end
        end
    end

`ifdef QEI_GEN_INDEX_EN
    localparam int RW = (CPR > 1) ? $clog2(CPR) : 1;

    logic [RW-1:0] r_rev;
    logic [RW-1:0] w_rev_nxt;
    logic          r_z;

    always_comb begin
        w_rev_nxt = r_rev;
        if (r_dir == QEI_FWD)
            w_rev_nxt = (r_rev == RW'(CPR - 1)) ? '0 : r_rev + 1'b1;
        else
            w_rev_nxt = (r_rev == '0) ? RW'(CPR - 1) : r_rev - 1'b1;
    end

    // z is registered alongside the edge so it lines up with A/B
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rev <= '0;
            r_z   <= 1'b1;
        end else if (w_step) begin
            r_rev <= w_rev_nxt;
            r_z   <= (w_rev_nxt == '0);
        end
    end

    assign o_enc_z = r_z;
`else
    assign o_enc_z = 1'b0;
`endif

    assign o_cmd_ready = (r_state == IDLE);
    assign o_busy      = w_run;
    assign o_enc_a     = r_ab[0];
    assign o_enc_b     = r_ab[1];
    assign o_position  = r_pos;
    assign o_done      = r_done;

endmodule
